// File: rtl/chip8_timers.sv
// CHIP-8 delay and sound timers, decremented by the 60 Hz tick, plus the
// gated square-wave tone that drives the speaker while the sound timer runs.
module chip8_timers #(
    parameter int CLOCK_HZ = 12_000_000,
    parameter int TONE_HZ  = 440,
    localparam int TONE_TOP = CLOCK_HZ / (2 * TONE_HZ) - 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_60hz,
    input  logic       dt_we,
    input  logic       st_we,
    input  logic [7:0] wdata,
    output logic [7:0] dt_value,
    output logic [7:0] st_value,
    output logic       sound_active,
    output logic       dt_expired,
    output logic       beep
);

    localparam logic [31:0] TONE_RELOAD = 32'(TONE_TOP);

    logic [31:0] tone_cnt;
    logic        tone_phase;

    // A write always wins over a coincident tick; the tick is simply consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dt_value   <= 8'd0;
            dt_expired <= 1'b0;
        end else begin
            dt_expired <= tick_60hz & ~dt_we & (dt_value == 8'd1);
            if (dt_we) begin
                dt_value <= wdata;
            end else if (tick_60hz && dt_value != 8'd0) begin
                dt_value <= dt_value - 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_value <= 8'd0;
        end else if (st_we) begin
            st_value <= wdata;
        end else if (tick_60hz && st_value != 8'd0) begin
            st_value <= st_value - 8'd1;
        end
    end

    // Held in its reload state while silent so every burst opens with a
    // full low half-period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tone_cnt   <= TONE_RELOAD;
            tone_phase <= 1'b0;
        end else if (st_value == 8'd0) begin
            tone_cnt   <= TONE_RELOAD;
            tone_phase <= 1'b0;
        end else if (tone_cnt == 32'd0) begin
            tone_cnt   <= TONE_RELOAD;
            tone_phase <= ~tone_phase;
        end else begin
            tone_cnt <= tone_cnt - 32'd1;
        end
    end

    assign sound_active = (st_value != 8'd0);
    assign beep         = tone_phase & sound_active;

endmodule

// File: tb/tb_chip8_timers.sv
// Bench for chip8_timers at CLOCK_HZ=1000, TONE_HZ=100 (half-period of 5 cycles).
// A behavioural model pushes expected outputs per driven cycle; they are popped after the edge.
module tb_chip8_timers;

    localparam int CLOCK_HZ = 1000;
    localparam int TONE_HZ  = 100;
    localparam int HALF     = CLOCK_HZ / (2 * TONE_HZ);

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick_60hz = 1'b0;
    logic       dt_we = 1'b0;
    logic       st_we = 1'b0;
    logic [7:0] wdata = 8'd0;
    logic [7:0] dt_value;
    logic [7:0] st_value;
    logic       sound_active;
    logic       dt_expired;
    logic       beep;

    chip8_timers #(.CLOCK_HZ(CLOCK_HZ), .TONE_HZ(TONE_HZ)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .tick_60hz    (tick_60hz),
        .dt_we        (dt_we),
        .st_we        (st_we),
        .wdata        (wdata),
        .dt_value     (dt_value),
        .st_value     (st_value),
        .sound_active (sound_active),
        .dt_expired   (dt_expired),
        .beep         (beep)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int pulses = 0;

    // {dt_value, st_value, sound_active, dt_expired, beep}
    logic [18:0] exp_q[$];

    int m_dt = 0;
    int m_st = 0;
    int m_burst = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_dt = 0;
        m_st = 0;
        m_burst = 0;
        exp_q.delete();
    endtask

    // Drive one cycle of stimulus, predict the post-edge outputs, then compare.
    task automatic step(input logic tk, input logic dwe, input logic swe, input logic [7:0] wd);
        logic        e_exp;
        int          new_st;
        logic        e_beep;
        logic [18:0] e;
        logic [18:0] got;
        tick_60hz = tk;
        dt_we     = dwe;
        st_we     = swe;
        wdata     = wd;
        e_exp = tk && !dwe && (m_dt == 1);
        if (dwe) m_dt = int'(wd);
        else if (tk && m_dt > 0) m_dt = m_dt - 1;
        if (swe) new_st = int'(wd);
        else if (tk && m_st > 0) new_st = m_st - 1;
        else new_st = m_st;
        if (new_st == 0 || m_st == 0) m_burst = 0;
        else m_burst = m_burst + 1;
        m_st = new_st;
        e_beep = (m_st != 0) && (((m_burst / HALF) % 2) == 1);
        exp_q.push_back({m_dt[7:0], m_st[7:0], (m_st != 0), e_exp, e_beep});
        @(posedge clk);
        #1;
        tick_60hz = 1'b0;
        dt_we     = 1'b0;
        st_we     = 1'b0;
        e = exp_q.pop_front();
        got = {dt_value, st_value, sound_active, dt_expired, beep};
        if (dt_expired === 1'b1) pulses++;
        check("dt_value", 32'(got[18:11]), 32'(e[18:11]));
        check("st_value", 32'(got[10:3]), 32'(e[10:3]));
        check("sound_active", 32'(got[2]), 32'(e[2]));
        check("dt_expired", 32'(got[1]), 32'(e[1]));
        check("beep", 32'(got[0]), 32'(e[0]));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 8'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_dt"}, 32'(dt_value), 32'd0);
        check({tag, "_st"}, 32'(st_value), 32'd0);
        check({tag, "_sound"}, 32'(sound_active), 32'd0);
        check({tag, "_exp"}, 32'(dt_expired), 32'd0);
        check({tag, "_beep"}, 32'(beep), 32'd0);
    endtask

    initial begin
        int p0;
        #12;
        check_all_zero("por");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Delay countdown 3 -> 0 with ticks spaced 7 cycles apart
        pulses = 0;
        step(1'b0, 1'b1, 1'b0, 8'd3);
        for (int k = 0; k < 3; k++) begin
            idle(6);
            step(1'b1, 1'b0, 1'b0, 8'd0);
        end
        idle(6);
        check("countdown_pulses", 32'(pulses), 32'd1);
        step(1'b1, 1'b0, 1'b0, 8'd0);
        idle(3);
        check("tick_at_zero_pulses", 32'(pulses), 32'd1);

        // Write/tick collision, then 1 and 0 written with no tick
        step(1'b0, 1'b1, 1'b0, 8'd10);
        idle(2);
        step(1'b1, 1'b1, 1'b0, 8'h20);
        check("collision_dt", 32'(dt_value), 32'h20);
        p0 = pulses;
        step(1'b0, 1'b1, 1'b0, 8'd1);
        step(1'b0, 1'b1, 1'b0, 8'd0);
        idle(4);
        check("write_zero_pulses", 32'(pulses), 32'(p0));

        // Sound burst of 2 ticks
        step(1'b0, 1'b0, 1'b1, 8'd2);
        idle(12);
        step(1'b1, 1'b0, 1'b0, 8'd0);
        idle(3);
        step(1'b1, 1'b0, 1'b0, 8'd0);
        idle(10);

        // Silence by write during the high phase, then restart
        step(1'b0, 1'b0, 1'b1, 8'd9);
        idle(HALF + 1);
        check("beep_high_before_silence", 32'(beep), 32'd1);
        step(1'b0, 1'b0, 1'b1, 8'd0);
        check("silence_beep", 32'(beep), 32'd0);
        step(1'b0, 1'b0, 1'b1, 8'd1);
        idle(12);
        step(1'b1, 1'b0, 1'b0, 8'd0);
        idle(3);

        // Both strobes at 0xFF, then saturation with irregular tick spacing
        step(1'b0, 1'b1, 1'b1, 8'hFF);
        check("both_load_dt", 32'(dt_value), 32'd255);
        check("both_load_st", 32'(st_value), 32'd255);
        for (int k = 0; k < 256; k++) begin
            idle($urandom_range(0, 2));
            step(1'b1, 1'b0, 1'b0, 8'd0);
        end
        check("sat_dt", 32'(dt_value), 32'd0);
        check("sat_st", 32'(st_value), 32'd0);

        // Reset asserted mid-burst clears everything asynchronously
        step(1'b0, 1'b0, 1'b1, 8'd5);
        step(1'b0, 1'b1, 1'b0, 8'd7);
        idle(HALF + 1);
        check("pre_reset_beep", 32'(beep), 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle(50);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
